// File: rtl/cp0_regs.sv
// cp0_regs: MIPS CP0 register file (Count/Compare/Status/Cause/EPC, exception commit, redirect); timer logic under CP0_TIMER_EN
module cp0_regs #(
  parameter int unsigned COUNT_DIV  = 1,
  parameter logic [31:0] HANDLER_PC = 32'h0000_0040,
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cp0we,
  input  logic [4:0]  cp0Addr,
  input  logic [31:0] cp0wData,
  output logic [31:0] cp0rData,
  input  logic [31:0] excptype,
  input  logic [31:0] pc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        excRedirect,
  output logic [31:0] newPc
);
  logic        exc_int, exc_sys, exc_ret, entry, wr, ti_d;
  logic [31:0] status_q, cause_q, epc_q, count_q, compare_q;
  assign exc_int = excptype[2];
  assign exc_sys = !excptype[2] && excptype[8];
  assign exc_ret = !excptype[2] && !excptype[8] && excptype[9];
  assign entry   = exc_int || exc_sys;
  assign wr      = cp0we && !entry && !exc_ret;
`ifdef CP0_TIMER_EN
  logic [7:0] presc_q;
  logic       tick, cnt_wr, cmp_wr;
  assign tick   = presc_q == 8'(COUNT_DIV - 1);
  assign cnt_wr = wr && cp0Addr == 5'd9;
  assign cmp_wr = wr && cp0Addr == 5'd11;
  assign ti_d   = cmp_wr ? 1'b0 : (count_q == compare_q && compare_q != 32'd0) ? 1'b1 : cause_q[10];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      presc_q   <= (cnt_wr || cmp_wr || tick) ? 8'd0 : presc_q + 8'd1;
      count_q   <= cnt_wr ? cp0wData : tick ? count_q + 32'd1 : count_q;
      compare_q <= cmp_wr ? cp0wData : compare_q;
    end
`else
  assign count_q   = '0;
  assign compare_q = '0;
  assign ti_d      = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= entry ? status_q | 32'h2 : exc_ret ? status_q & ~32'h2 :
                  (wr && cp0Addr == 5'd12) ? cp0wData & 32'h0000_FF03 : status_q;
      cause_q  <= {21'd0, ti_d, (wr && cp0Addr == 5'd13) ? cp0wData[9:8] : cause_q[9:8], 1'b0,
                   entry ? (exc_int ? 5'd0 : 5'd8) : cause_q[6:2], 2'b00};
      epc_q    <= entry ? pc : (wr && cp0Addr == 5'd14) ? cp0wData : epc_q;
    end
  assign status      = status_q;
  assign cause       = cause_q;
  assign epc         = epc_q;
  assign excRedirect = |excptype;
  assign newPc       = !excRedirect ? 32'd0 : exc_ret ? epc_q : HANDLER_PC;
  assign cp0rData    = cp0Addr == 5'd9  ? count_q :
                       cp0Addr == 5'd11 ? compare_q :
                       cp0Addr == 5'd12 ? status_q :
                       cp0Addr == 5'd13 ? cause_q :
                       cp0Addr == 5'd14 ? epc_q : 32'd0;
endmodule
